// File: rtl/stream_extreme_tracker_pkg.sv
// stream_extreme_pkg
// Shared types and helpers for the streaming extreme-value tracker.
//   state_t  : frame FSM states (idle / accumulating)
//   cntSat() : saturation value of an IDX_W-bit counter, (1<<IDX_W)-1
package stream_extreme_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam int DEFAULT_IDX_W = 4;

  // Largest value an idxW-bit sample counter can hold before it saturates.
  function automatic int cntSat(input int idxW);
    return (1 << idxW) - 1;
  endfunction

endpackage

// File: rtl/stream_extreme_tracker_if.sv
// stream_extreme_tracker_if
// Groups the sample-in and result-out handshakes of the tracker.
//   in_valid/in_ready/in_data/in_last/mode_min : sample stream (source -> tracker)
//   out_valid/out_ready/out_val/out_idx/out_cnt/out_ovf : per-frame result
// Modports: master = source/consumer side, slave = tracker side.
interface stream_extreme_tracker_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode_min;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, mode_min, out_ready,
    input  in_ready, out_valid, out_val, out_idx, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, mode_min, out_ready,
    output in_ready, out_valid, out_val, out_idx, out_cnt, out_ovf
  );

endinterface

// File: rtl/stream_extreme_tracker_cmp.sv
// extreme_cmp
// Combinational "is b strictly better than a" comparator slice.
//   a        : current best value
//   b        : candidate value
//   mode_min : 1 = smaller is better, 0 = larger is better
//   take_b   : candidate strictly beats current best (ties keep a)
// Kept as its own module so approximated comparator variants can drop in.
module extreme_cmp #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode_min,
  output logic             take_b
);

  logic w_bLess;
  logic w_bGreater;

  // Pick the compare flavour at elaboration time; the data itself is never
  // widened, only reinterpreted as signed when requested.
  generate
    if (SIGNED) begin : g_signed
      assign w_bLess    = $signed(b) < $signed(a);
      assign w_bGreater = $signed(b) > $signed(a);
    end else begin : g_unsigned
      assign w_bLess    = b < a;
      assign w_bGreater = b > a;
    end
  endgenerate

  // Strict comparison so the earliest occurrence of a tie wins.
  assign take_b = mode_min ? w_bLess : w_bGreater;

endmodule

// File: rtl/stream_extreme_tracker.sv
// stream_extreme_tracker
// Tracks the max or min sample of each in_last-delimited frame and reports
// value, first-occurrence index, saturating count-1 and an overflow flag.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (discards any frame in progress)
//   bus  : slave modport carrying the sample stream and result handshake
module stream_extreme_tracker
  import stream_extreme_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IDX_W  = DEFAULT_IDX_W,
  parameter bit SIGNED = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_extreme_tracker_if.slave bus
);

  localparam logic [IDX_W-1:0] CNT_SAT = IDX_W'(cntSat(IDX_W));

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_accVal;
  logic [WIDTH-1:0] w_accValNext;
  logic [IDX_W-1:0] r_accIdx;
  logic [IDX_W-1:0] w_accIdxNext;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cntNext;
  logic             r_ovf;
  logic             w_ovfNext;
  logic             r_modeMin;
  logic             w_modeNext;
  logic             w_load;
  logic             w_takeB;
  logic             w_inReady;
  logic             w_inFire;
  logic             w_outFire;

  logic             r_outValid;
  logic [WIDTH-1:0] r_outVal;
  logic [IDX_W-1:0] r_outIdx;
  logic [IDX_W-1:0] r_outCnt;
  logic             r_outOvf;

  // The only combinational path: a full result slot frees up for a new
  // sample in the same cycle the consumer takes it.
  assign w_inReady = ~r_outValid | bus.out_ready;
  assign w_inFire  = bus.in_valid & w_inReady;
  assign w_outFire = r_outValid & bus.out_ready;

  extreme_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a        (r_accVal),
    .b        (bus.in_data),
    .mode_min (r_modeMin),
    .take_b   (w_takeB)
  );

  // Next-state logic for the accumulator. The first beat of a frame seeds
  // every field and latches the mode; later beats advance the saturating
  // counter and replace the best value only on a strict improvement, using
  // the already-advanced count as the index.
  always_comb begin
    w_stateNext  = r_state;
    w_accValNext = r_accVal;
    w_accIdxNext = r_accIdx;
    w_cntNext    = r_cnt;
    w_ovfNext    = r_ovf;
    w_modeNext   = r_modeMin;
    w_load       = 1'b0;
    if (w_inFire) begin
      case (r_state)
        ST_IDLE: begin
          w_accValNext = bus.in_data;
          w_accIdxNext = '0;
          w_cntNext    = '0;
          w_ovfNext    = 1'b0;
          w_modeNext   = bus.mode_min;
          if (bus.in_last) begin
            w_load = 1'b1;
          end else begin
            w_stateNext = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (r_cnt == CNT_SAT) begin
            w_ovfNext = 1'b1;
          end else begin
            w_cntNext = r_cnt + 1'b1;
          end
          if (w_takeB) begin
            w_accValNext = bus.in_data;
            w_accIdxNext = w_cntNext;
          end
          if (bus.in_last) begin
            w_load      = 1'b1;
            w_stateNext = ST_IDLE;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // Accumulator and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_accVal  <= '0;
      r_accIdx  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_modeMin <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_accVal  <= w_accValNext;
      r_accIdx  <= w_accIdxNext;
      r_cnt     <= w_cntNext;
      r_ovf     <= w_ovfNext;
      r_modeMin <= w_modeNext;
    end
  end

  // Result slot: loads the final post-update frame values on a last beat and
  // otherwise holds until accepted. A load in the acceptance cycle wins, so
  // out_valid stays high with the new frame's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outVal   <= '0;
      r_outIdx   <= '0;
      r_outCnt   <= '0;
      r_outOvf   <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outVal   <= w_accValNext;
      r_outIdx   <= w_accIdxNext;
      r_outCnt   <= w_cntNext;
      r_outOvf   <= w_ovfNext;
    end else if (w_outFire) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_val   = r_outVal;
  assign bus.out_idx   = r_outIdx;
  assign bus.out_cnt   = r_outCnt;
  assign bus.out_ovf   = r_outOvf;

endmodule

// File: tb/tb_stream_extreme_tracker.sv
// tb_stream_extreme_tracker
// Directed bench: an unsigned tracker (dut0) and a signed tracker (dut1)
// share clock and reset; each scenario task drives beats on the falling
// edge and checks results on the falling edge after the accepting edge.
module tb_stream_extreme_tracker;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  stream_extreme_tracker_if #(.WIDTH(8), .IDX_W(4)) bus0 ();
  stream_extreme_tracker_if #(.WIDTH(8), .IDX_W(4)) bus1 ();

  stream_extreme_tracker #(.WIDTH(8), .IDX_W(4), .SIGNED(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  stream_extreme_tracker #(.WIDTH(8), .IDX_W(4), .SIGNED(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one beat to the selected tracker starting at a falling edge and
  // returns at the falling edge after it transfers; stalls = cycles waited.
  task automatic sendBeat(input int sel, input logic [7:0] d, input logic last,
                          input logic mm, output int stalls);
    logic rdy;
    int   n;
    rdy = 1'b0;
    if (sel == 0) begin
      bus0.in_valid = 1'b1; bus0.in_data = d; bus0.in_last = last; bus0.mode_min = mm;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = last; bus1.mode_min = mm;
    end
    for (n = 0; n < 20; n++) begin
      #1;
      rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
      if (rdy) break;
      @(negedge clk);
    end
    stalls = n;
    if (!rdy) begin
      checks++; errors++;
      $display("[TB] FAIL beat_timeout got in_ready=0 for 20 cycles want 1");
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_val !== 8'h00 || bus0.out_idx !== 4'd0 ||
        bus0.out_cnt !== 4'd0 || bus0.out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%0b val=%0h idx=%0d cnt=%0d ovf=%0b want all 0",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt, bus0.out_ovf);
    end
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %0b want 1", bus0.in_ready);
    end
  endtask

  // Max frame 3,9,9,2; mode_min toggles after the first beat and must be ignored.
  task automatic test_max_unsigned();
    int s;
    sendBeat(0, 8'd3, 1'b0, 1'b0, s);
    sendBeat(0, 8'd9, 1'b0, 1'b1, s);
    sendBeat(0, 8'd9, 1'b0, 1'b1, s);
    sendBeat(0, 8'd2, 1'b1, 1'b1, s);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'd9 || bus0.out_idx !== 4'd1 ||
        bus0.out_cnt !== 4'd3 || bus0.out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_result got v=%0b val=%0d idx=%0d cnt=%0d ovf=%0b want 1 9 1 3 0",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt, bus0.out_ovf);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL max_drain got out_valid=%0b want 0", bus0.out_valid);
    end
  endtask

  // Same frame through the signed and the unsigned tracker in min mode.
  task automatic test_min_signed();
    int s;
    sendBeat(1, 8'h05, 1'b0, 1'b1, s);
    sendBeat(1, 8'hF0, 1'b0, 1'b0, s);
    sendBeat(1, 8'h80, 1'b0, 1'b0, s);
    sendBeat(1, 8'h7F, 1'b1, 1'b0, s);
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_val !== 8'h80 || bus1.out_idx !== 4'd2 ||
        bus1.out_cnt !== 4'd3) begin
      errors++;
      $display("[TB] FAIL min_signed got v=%0b val=%0h idx=%0d cnt=%0d want 1 80 2 3",
               bus1.out_valid, bus1.out_val, bus1.out_idx, bus1.out_cnt);
    end
    sendBeat(0, 8'h05, 1'b0, 1'b1, s);
    sendBeat(0, 8'hF0, 1'b0, 1'b0, s);
    sendBeat(0, 8'h80, 1'b0, 1'b0, s);
    sendBeat(0, 8'h7F, 1'b1, 1'b0, s);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'h05 || bus0.out_idx !== 4'd0 ||
        bus0.out_cnt !== 4'd3) begin
      errors++;
      $display("[TB] FAIL min_unsigned got v=%0b val=%0h idx=%0d cnt=%0d want 1 05 0 3",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt);
    end
    @(negedge clk);
  endtask

  // Single-beat frame followed immediately by a two-beat frame.
  task automatic test_back_to_back();
    int s;
    sendBeat(0, 8'h42, 1'b1, 1'b0, s);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'h42 || bus0.out_idx !== 4'd0 ||
        bus0.out_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL single_beat got v=%0b val=%0h idx=%0d cnt=%0d want 1 42 0 0",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt);
    end
    sendBeat(0, 8'h10, 1'b0, 1'b0, s);
    checks++;
    if (s !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_stall got %0d stall cycles want 0", s);
    end
    sendBeat(0, 8'h20, 1'b1, 1'b0, s);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'h20 || bus0.out_idx !== 4'd1 ||
        bus0.out_cnt !== 4'd1) begin
      errors++;
      $display("[TB] FAIL b2b_second got v=%0b val=%0h idx=%0d cnt=%0d want 1 20 1 1",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt);
    end
    @(negedge clk);
  endtask

  // Result held under out_ready=0 while a new last beat waits; releasing
  // out_ready lets both transfer on the same edge.
  task automatic test_backpressure();
    int  s;
    bit  ok;
    bus0.out_ready = 1'b0;
    sendBeat(0, 8'h07, 1'b1, 1'b0, s);
    bus0.in_valid = 1'b1; bus0.in_data = 8'h33; bus0.in_last = 1'b1; bus0.mode_min = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1 || bus0.out_val !== 8'h07 ||
          bus0.out_cnt !== 4'd0) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL bp_hold got rdy=%0b v=%0b val=%0h want rdy=0 v=1 val=07 held",
               bus0.in_ready, bus0.out_valid, bus0.out_val);
    end
    bus0.out_ready = 1'b1;
    #1;
    checks++;
    if (bus0.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release_ready got %0b want 1", bus0.in_ready);
    end
    @(negedge clk);
    bus0.in_valid = 1'b0;
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'h33) begin
      errors++;
      $display("[TB] FAIL bp_reload got v=%0b val=%0h want 1 33", bus0.out_valid, bus0.out_val);
    end
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drain got out_valid=%0b want 0", bus0.out_valid);
    end
  endtask

  // 20-beat frame, maximum 0xAA at beat 18: count and index both saturate.
  task automatic test_overflow();
    int s;
    for (int i = 0; i < 20; i++) begin
      sendBeat(0, (i == 18) ? 8'hAA : 8'h01, (i == 19), 1'b0, s);
    end
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'hAA || bus0.out_idx !== 4'd15 ||
        bus0.out_cnt !== 4'd15 || bus0.out_ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow got v=%0b val=%0h idx=%0d cnt=%0d ovf=%0b want 1 aa 15 15 1",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt, bus0.out_ovf);
    end
    @(negedge clk);
  endtask

  // Reset after two beats of an unfinished frame; the stale 0x60 must not
  // leak into the following frame 1,4.
  task automatic test_reset_midframe();
    int s;
    sendBeat(0, 8'h50, 1'b0, 1'b0, s);
    sendBeat(0, 8'h60, 1'b0, 1'b0, s);
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.out_valid !== 1'b0 || bus0.out_val !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midrst_during got v=%0b val=%0h want 0 00", bus0.out_valid, bus0.out_val);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_after got out_valid=%0b want 0", bus0.out_valid);
    end
    sendBeat(0, 8'd1, 1'b0, 1'b0, s);
    sendBeat(0, 8'd4, 1'b1, 1'b0, s);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.out_val !== 8'd4 || bus0.out_idx !== 4'd1 ||
        bus0.out_cnt !== 4'd1 || bus0.out_ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_next got v=%0b val=%0h idx=%0d cnt=%0d ovf=%0b want 1 04 1 1 0",
               bus0.out_valid, bus0.out_val, bus0.out_idx, bus0.out_cnt, bus0.out_ovf);
    end
    @(negedge clk);
  endtask

  // Scenario sequence.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_last = 1'b0; bus0.mode_min = 1'b0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0; bus1.mode_min = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_max_unsigned();
    test_min_signed();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
